// File: rtl/rsa_pkg.sv
// Shared types and width helpers for the RSA modular exponentiation unit.
package rsa_pkg;

    typedef enum logic [2:0] {IDLE, INIT, EXP, FINAL, REDUCE, DONE} state_t;

    // Internal Montgomery datapath width; radix R = 2^w2_of(width).
    function automatic int w2_of(input int width);
        return width + 2;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic int idx_width(input int exp_width);
        return $clog2(exp_width + 1);
    endfunction

endpackage

// File: rtl/mmm_serial_core.sv
// Bit-serial Montgomery multiplier: one iteration of Acc = (Acc + a_i*B + q*M) >> 1 per step.
module mmm_serial_core #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic         clr,
    input  logic         step,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] M,
    output logic [W-1:0] R
);

    logic [W-1:0] acc_q;
    logic [W-1:0] a_q;
    logic [W:0]   acc_in;
    logic [W:0]   sum;
    logic [W:0]   sum_q;
    logic         a_bit;

    // clr treats Acc as zero and takes a_0 straight from A, so no idle cycle at phase entry
    always_comb begin
        acc_in = clr ? '0 : {1'b0, acc_q};
        a_bit  = clr ? A[0] : a_q[0];
        sum    = acc_in + (a_bit ? {1'b0, B} : '0);
        sum_q  = sum + (sum[0] ? {1'b0, M} : '0);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            acc_q <= '0;
            a_q   <= '0;
        end else if (en && step) begin
            acc_q <= W'(sum_q >> 1);
            a_q   <= clr ? (A >> 1) : (a_q >> 1);
        end
    end

    assign R = acc_q;

endmodule

// File: rtl/rsa_modexp_unit.sv
// C = P^E mod M using two parallel Montgomery multipliers (S and X paths).
// Optional RSA_MODEXP_EARLY_EXIT_EN: stop EXP after the highest set exponent bit.
module rsa_modexp_unit
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Const,
    output logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int W2 = w2_of(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam int IW = idx_width(EXP_WIDTH);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     p_r, m_r, k_r;
    logic [EXP_WIDTH-1:0] e_sh;
    logic [W2-1:0]        s_hold, s_res, x_res, s_op, m_ext;
    logic [W2-1:0]        s_a, s_b, x_a, x_b;
    logic                 s_step, x_step, clr;
    logic                 m_ok, phase_last, exp_last, skip_exp, x_ge;

    assign m_ext      = W2'(m_r);
    assign m_ok       = m_r[0] && (m_r >= WIDTH'(3));
    assign phase_last = (cnt_q == CW'(W2 - 1));
    assign clr        = (cnt_q == '0);
    assign x_ge       = (x_res >= m_ext);

`ifdef RSA_MODEXP_EARLY_EXIT_EN
    assign exp_last = ((e_sh >> 1) == '0);
    assign skip_exp = (e_sh == '0);
`else
    logic [IW-1:0] idx_q;

    assign exp_last = (idx_q == IW'(EXP_WIDTH - 1));
    assign skip_exp = 1'b0;

    always_ff @(posedge clk) begin
        if (!rstb)
            idx_q <= '0;
        else if (en) begin
            if (state_q == IDLE)
                idx_q <= '0;
            else if (state_q == EXP && phase_last)
                idx_q <= idx_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstb)
            state_q <= IDLE;
        else if (en)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    if (!m_ok) state_d = DONE;
                     else if (phase_last) state_d = skip_exp ? FINAL : EXP;
            EXP:     if (phase_last && exp_last) state_d = FINAL;
            FINAL:   if (phase_last) state_d = REDUCE;
            REDUCE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pre-phase S is the core output on the first cycle of EXP and the held copy afterwards
    assign s_op   = clr ? s_res : s_hold;
    assign s_a    = (state_q == INIT) ? W2'(p_r) : s_res;
    assign s_b    = (state_q == INIT) ? W2'(k_r) : s_op;
    assign x_a    = (state_q == INIT) ? W2'(1) : x_res;
    assign x_b    = (state_q == INIT) ? W2'(k_r) : (state_q == EXP) ? s_op : W2'(1);
    assign s_step = (state_q == INIT && m_ok) || (state_q == EXP);
    assign x_step = (state_q == INIT && m_ok) || (state_q == EXP && e_sh[0]) || (state_q == FINAL);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_q  <= '0;
            p_r    <= '0;
            m_r    <= '0;
            k_r    <= '0;
            e_sh   <= '0;
            s_hold <= '0;
            C      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        p_r   <= P;
                        e_sh  <= E;
                        m_r   <= M;
                        k_r   <= Const;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                INIT: begin
                    if (!m_ok) begin
                        C    <= '0;
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                    cnt_q <= phase_last ? '0 : cnt_q + 1'b1;
                end
                EXP: begin
                    if (clr)
                        s_hold <= s_res;
                    if (phase_last)
                        e_sh <= e_sh >> 1;
                    cnt_q <= phase_last ? '0 : cnt_q + 1'b1;
                end
                FINAL: cnt_q <= phase_last ? '0 : cnt_q + 1'b1;
                REDUCE: begin
                    C    <= WIDTH'(x_ge ? x_res - m_ext : x_res);
                    done <= 1'b1;
                end
                DONE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mmm_serial_core #(.W(W2)) u_s_core (
        .clk  (clk),
        .rstb (rstb),
        .en   (en),
        .clr  (clr),
        .step (s_step),
        .A    (s_a),
        .B    (s_b),
        .M    (m_ext),
        .R    (s_res)
    );

    mmm_serial_core #(.W(W2)) u_x_core (
        .clk  (clk),
        .rstb (rstb),
        .en   (en),
        .clr  (clr),
        .step (x_step),
        .A    (x_a),
        .B    (x_b),
        .M    (m_ext),
        .R    (x_res)
    );

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed self-checking bench for rsa_modexp_unit at WIDTH=8, EXP_WIDTH=8.
module tb_rsa_modexp_unit;

    localparam int WIDTH     = 8;
    localparam int EXP_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rstb, en, start;
    logic [WIDTH-1:0]     P, M, Const, C;
    logic [EXP_WIDTH-1:0] E;
    logic                 busy, done, err;
    int                   errors = 0;
    int                   checks = 0;

    rsa_modexp_unit #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .en    (en),
        .start (start),
        .P     (P),
        .E     (E),
        .M     (M),
        .Const (Const),
        .C     (C),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Valid-modulus latency (n+2)*W2+2 with W2=10
    function automatic int lat(input logic [7:0] e);
        int n, msb_n;
        msb_n = 0;
        for (int i = 0; i < 8; i++)
            if (e[i]) msb_n = i + 1;
        n = EXP_WIDTH;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        n = msb_n;
`endif
        return (n + 2) * 10 + 2;
    endfunction

    task automatic do_op(input string tag, input logic [7:0] p, input logic [7:0] e,
                         input logic [7:0] m, input logic [7:0] k, input logic [7:0] c_exp,
                         input logic err_exp, input int l_exp,
                         input int again_at, input int en_at, input int rst_at);
        int cyc;
        @(negedge clk);
        P = p; E = e; M = m; Const = k; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; P = ~p; E = ~e; M = 8'd186; Const = ~k;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (cyc == again_at) begin
                P = 8'd1; E = 8'd1; M = 8'd187; Const = 8'd67; start = 1'b1;
            end
            if (cyc == en_at) begin
                en = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                check({tag, " frozen busy"}, 32'(busy), 32'd1);
                check({tag, " frozen done"}, 32'(done), 32'd0);
                en = 1'b1;
            end
            if (cyc == rst_at) begin
                check({tag, " busy before reset"}, 32'(busy), 32'd1);
                rstb = 1'b0;
                @(posedge clk);
                #1;
                check({tag, " reset busy"}, 32'(busy), 32'd0);
                check({tag, " reset done"}, 32'(done), 32'd0);
                check({tag, " reset err"}, 32'(err), 32'd0);
                check({tag, " reset C"}, 32'(C), 32'd0);
                rstb = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
        end
        check({tag, " done seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(l_exp));
        check({tag, " C"}, 32'(C), 32'(c_exp));
        check({tag, " err"}, 32'(err), 32'(err_exp));
        check({tag, " busy at done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " C held"}, 32'(C), 32'(c_exp));
    endtask

    initial begin
        rstb = 1'b0; en = 1'b1; start = 1'b0;
        P = '0; E = '0; M = '0; Const = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset C", 32'(C), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rstb = 1'b1;

        do_op("encrypt",  8'd88,  8'd7,   8'd187, 8'd67, 8'd11, 1'b0, lat(8'd7),   -1, -1, -1);
        do_op("decrypt",  8'd11,  8'd23,  8'd187, 8'd67, 8'd88, 1'b0, lat(8'd23),  -1, -1, -1);
        do_op("e_zero",   8'd88,  8'd0,   8'd187, 8'd67, 8'd1,  1'b0, lat(8'd0),   -1, -1, -1);
        do_op("p_zero",   8'd0,   8'd5,   8'd187, 8'd67, 8'd0,  1'b0, lat(8'd5),   -1, -1, -1);
        do_op("p_big",    8'd255, 8'd1,   8'd187, 8'd67, 8'd68, 1'b0, lat(8'd1),   -1, -1, -1);
        do_op("pow2",     8'd2,   8'd10,  8'd187, 8'd67, 8'd89, 1'b0, lat(8'd10),  -1, -1, -1);
        do_op("p_eq_m",   8'd187, 8'd0,   8'd187, 8'd67, 8'd1,  1'b0, lat(8'd0),   -1, -1, -1);
        do_op("m13",      8'd7,   8'd2,   8'd13,  8'd9,  8'd10, 1'b0, lat(8'd2),   -1, -1, -1);
        do_op("m13_pbig", 8'd200, 8'd1,   8'd13,  8'd9,  8'd5,  1'b0, lat(8'd1),   -1, -1, -1);
        do_op("m3",       8'd2,   8'd3,   8'd3,   8'd1,  8'd2,  1'b0, lat(8'd3),   -1, -1, -1);
        do_op("m_even",   8'd88,  8'd7,   8'd186, 8'd67, 8'd0,  1'b1, 2,           -1, -1, -1);
        do_op("refill",   8'd88,  8'd7,   8'd187, 8'd67, 8'd11, 1'b0, lat(8'd7),   -1, -1, -1);
        do_op("m_one",    8'd88,  8'd7,   8'd1,   8'd0,  8'd0,  1'b1, 2,           -1, -1, -1);
        do_op("restart",  8'd88,  8'd7,   8'd187, 8'd67, 8'd11, 1'b0, lat(8'd7),   30, -1, -1);
        do_op("en_stall", 8'd11,  8'd23,  8'd187, 8'd67, 8'd88, 1'b0, lat(8'd23)+10, -1, 20, -1);
        do_op("abort",    8'd88,  8'd7,   8'd187, 8'd67, 8'd11, 1'b0, lat(8'd7),   -1, -1, 50);
        @(posedge clk);
        #1;
        do_op("post_rst", 8'd88,  8'd7,   8'd187, 8'd67, 8'd11, 1'b0, lat(8'd7),   -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
